// File: rtl/pipeline_bp_if_multi_if.sv
// Stream bundle: data, valid/ready handshake, packet framing (sop/eop/err/mod) and ctl sideband.
interface if_axi_stream #(
    parameter int DAT_BYTS = 8,
    parameter int CTL_BITS = 8
);
    localparam int DAT_BITS = DAT_BYTS * 8;
    localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

    logic [DAT_BITS-1:0] dat;
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;
    logic [MOD_BITS-1:0] mod;
    logic [CTL_BITS-1:0] ctl;

    modport sink (input dat, val, sop, eop, err, mod, ctl, output rdy);
    modport src  (output dat, val, sop, eop, err, mod, ctl, input rdy);
endinterface

// File: rtl/pipeline_bp_if_multi.sv
// Chain of skid-buffered register slices with registered ready; every hop breaks both the
// forward (val/data) and backward (rdy) timing paths while sustaining one beat per cycle.
module pipeline_bp_if_multi #(
    parameter int  DAT_BYTS   = 8,
    parameter int  DAT_BITS   = DAT_BYTS * 8,
    parameter int  CTL_BITS   = 8,
    parameter int  NUM_STAGES = 2,
    parameter int  RANDOM_BP  = 0,
    localparam int OCC_W      = (NUM_STAGES > 0) ? $clog2(2 * NUM_STAGES + 1) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    if_axi_stream.sink       i_if,
    if_axi_stream.src        o_if,
    output logic [OCC_W-1:0] o_occ
);
    localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;
    localparam int PAY_W    = 3 + MOD_BITS + CTL_BITS + DAT_BITS;

    logic             bp;
    logic [PAY_W-1:0] in_pay;

    assign in_pay = {i_if.sop, i_if.eop, i_if.err, i_if.mod, i_if.ctl, i_if.dat};

    // Optional pseudo-random stall injection for stress runs; RANDOM_BP=0 ties bp high.
    if (RANDOM_BP > 0) begin : g_bp
        logic [15:0] lfsr_q, lfsr_d;
        logic        bp_q, bp_d;

        always_comb begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            bp_d   = ((32'(lfsr_q[7:0]) * 32'd100) >> 8) >= 32'(RANDOM_BP);
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                lfsr_q <= 16'hACE1;
                bp_q   <= 1'b1;
            end else begin
                lfsr_q <= lfsr_d;
                bp_q   <= bp_d;
            end
        end

        assign bp = bp_q;
    end else begin : g_nobp
        assign bp = 1'b1;
    end

    if (NUM_STAGES == 0) begin : g_pass
        assign o_if.val = i_if.val & bp;
        assign {o_if.sop, o_if.eop, o_if.err, o_if.mod, o_if.ctl, o_if.dat} = in_pay;
        assign i_if.rdy = o_if.rdy & bp;
        assign o_occ    = '0;
    end else begin : g_pipe
        // Index k of each chain vector is the boundary feeding stage k; index NUM_STAGES is o_if.
        logic [NUM_STAGES:0] val_c;
        logic [NUM_STAGES:0] rdy_c;
        logic [PAY_W-1:0]    pay_c [NUM_STAGES+1];
        logic [OCC_W-1:0]    occ_q, occ_d;
        logic                in_xfer, out_xfer;

        assign val_c[0]          = i_if.val & bp;
        assign pay_c[0]          = in_pay;
        assign rdy_c[NUM_STAGES] = o_if.rdy;
        assign i_if.rdy          = rdy_c[0] & bp;

        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
            logic [PAY_W-1:0] m_q, m_d, s_q, s_d;
            logic             m_val_q, m_val_d, s_val_q, s_val_d, rdy_q;
            logic             in_x, acc;

            assign in_x = val_c[k] & rdy_c[k];
            assign acc  = m_val_q & rdy_c[k+1];

            always_comb begin
                m_d     = m_q;
                m_val_d = m_val_q;
                s_d     = s_q;
                s_val_d = s_val_q;
                if (!m_val_q || acc) begin
                    if (s_val_q) begin
                        m_d     = s_q;
                        m_val_d = 1'b1;
                        if (in_x) begin
                            s_d = pay_c[k];
                        end else begin
                            s_val_d = 1'b0;
                        end
                    end else begin
                        m_val_d = in_x;
                        if (in_x) begin
                            m_d = pay_c[k];
                        end
                    end
                end else if (in_x) begin
                    // Main is stalled; the beat already in flight lands in the skid slot.
                    s_d     = pay_c[k];
                    s_val_d = 1'b1;
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    m_q     <= '0;
                    s_q     <= '0;
                    m_val_q <= 1'b0;
                    s_val_q <= 1'b0;
                    rdy_q   <= 1'b0;
                end else begin
                    m_q     <= m_d;
                    s_q     <= s_d;
                    m_val_q <= m_val_d;
                    s_val_q <= s_val_d;
                    rdy_q   <= ~s_val_d;
                end
            end

            assign rdy_c[k]   = rdy_q;
            assign val_c[k+1] = m_val_q;
            assign pay_c[k+1] = m_q;
        end

        assign in_xfer  = val_c[0] & rdy_c[0];
        assign out_xfer = val_c[NUM_STAGES] & rdy_c[NUM_STAGES];

        always_comb begin
            occ_d = occ_q;
            if (in_xfer && !out_xfer) begin
                occ_d = occ_q + 1'b1;
            end else if (!in_xfer && out_xfer) begin
                occ_d = occ_q - 1'b1;
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_d;
            end
        end

        assign o_if.val = val_c[NUM_STAGES];
        assign {o_if.sop, o_if.eop, o_if.err, o_if.mod, o_if.ctl, o_if.dat} = pay_c[NUM_STAGES];
        assign o_occ    = occ_q;
    end
endmodule

// File: tb/tb_pipeline_bp_if_multi.sv
// Scoreboard bench: directed flow on a 3-stage chain plus stressed instances at 0, 1 and 4 stages.
`timescale 1ns/1ps
module tb_pipeline_bp_if_multi;
    typedef struct packed {
        logic        sop;
        logic        eop;
        logic        err;
        logic [2:0]  mod;
        logic [7:0]  ctl;
        logic [63:0] dat;
    } beat_t;

    localparam int NB = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(8)) in_if ();
    if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(8)) out_if ();
    logic [2:0] occ;

    pipeline_bp_if_multi #(.DAT_BYTS(8), .CTL_BITS(8), .NUM_STAGES(3), .RANDOM_BP(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_if(in_if), .o_if(out_if), .o_occ(occ));

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input int i, input int n, input logic [63:0] d);
        beat_t b;
        b.sop = (i == 0);
        b.eop = (i == n - 1);
        b.err = (i == 57);
        b.mod = 3'(i);
        b.ctl = 8'(i) ^ 8'h5A;
        b.dat = d;
        return b;
    endfunction

    // ---------------- main scoreboard ----------------
    beat_t exp_q[$];
    beat_t cur, prev_beat;
    logic  prev_stall = 1'b0;
    int    phase = 0, acc_cnt = 0, t_in = -1, t_out = -1, t_last = 0, out_cnt = 0;
    logic  tog = 1'b0;

    task automatic send(input beat_t b);
        int w = 0;
        in_if.val = 1'b1;
        {in_if.sop, in_if.eop, in_if.err, in_if.mod, in_if.ctl, in_if.dat} = b;
        @(negedge clk);
        while (!in_if.rdy && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (!in_if.rdy) begin
            chk("send_rdy", 80'(in_if.rdy), 80'(1));
            in_if.val = 1'b0;
            return;
        end
        exp_q.push_back(b);
        acc_cnt++;
        if (phase == 2 && t_in < 0) t_in = cyc;
        @(posedge clk);
        #1;
        in_if.val = 1'b0;
    endtask

    task automatic wait_empty();
        int w = 0;
        while (exp_q.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        chk("drain", 80'(exp_q.size()), 80'(0));
    endtask

    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            cur = {out_if.sop, out_if.eop, out_if.err, out_if.mod, out_if.ctl, out_if.dat};
            chk("occ", 80'(occ), 80'(exp_q.size() - ((in_if.val && in_if.rdy) ? 1 : 0)));
            if (prev_stall) chk("stable", 80'({out_if.val, cur}), 80'({1'b1, prev_beat}));
            if (out_if.val && out_if.rdy) begin
                if (exp_q.size() == 0) chk("underflow", 80'(exp_q.size()), 80'(1));
                else chk("beat", 80'(cur), 80'(exp_q.pop_front()));
                if (phase == 2) begin
                    if (t_out < 0) t_out = cyc;
                    t_last = cyc;
                    out_cnt++;
                end
            end
            prev_stall = out_if.val && !out_if.rdy;
            prev_beat  = cur;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (tog) out_if.rdy = ~out_if.rdy;
    end

    initial begin
        int w;
        rst = 1'b1;
        in_if.val = 1'b1;
        {in_if.sop, in_if.eop, in_if.err, in_if.mod, in_if.ctl, in_if.dat} = '0;
        out_if.rdy = 1'b0;

        // reset with input valid held high
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_oval", 80'(out_if.val), 80'(0));
        chk("rst_irdy", 80'(in_if.rdy), 80'(0));
        chk("rst_occ", 80'(occ), 80'(0));
        chk("rst_odat", 80'(out_if.dat), 80'(0));
        #1;
        rst = 1'b0;
        in_if.val = 1'b0;
        @(negedge clk);
        chk("rel_irdy", 80'(in_if.rdy), 80'(1));

        // 16 beats back-to-back, output always ready
        @(posedge clk);
        #1;
        phase = 2;
        out_if.rdy = 1'b1;
        for (int i = 0; i < 16; i++) send(mk(i, 16, 64'(i)));
        wait_empty();
        chk("latency", 80'(t_out - t_in), 80'(3));
        chk("out_count", 80'(out_cnt), 80'(16));
        chk("back_to_back", 80'(t_last - t_out), 80'(15));
        phase = 0;

        // fill to capacity with output stalled, then release
        @(posedge clk);
        #1;
        out_if.rdy = 1'b0;
        acc_cnt = 0;
        fork
            for (int i = 0; i < 16; i++) send(mk(i, 16, 64'(100 + i)));
            begin
                repeat (20) @(negedge clk);
                chk("full_acc", 80'(acc_cnt), 80'(6));
                chk("full_irdy", 80'(in_if.rdy), 80'(0));
                chk("full_occ", 80'(occ), 80'(6));
                @(posedge clk);
                #1;
                out_if.rdy = 1'b1;
            end
        join
        wait_empty();

        // 100-beat packet with alternating output ready
        @(posedge clk);
        #1;
        tog = 1'b1;
        for (int i = 0; i < 100; i++) send(mk(i, 100, 64'h1000 + 64'(i)));
        wait_empty();
        tog = 1'b0;
        @(posedge clk);
        #1;

        // reset while 4 beats of a packet are held
        out_if.rdy = 1'b0;
        for (int i = 0; i < 4; i++) send(mk(i, 10, 64'h2000 + 64'(i)));
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_oval", 80'(out_if.val), 80'(0));
        chk("mid_rst_occ", 80'(occ), 80'(0));
        chk("mid_rst_odat", 80'(out_if.dat), 80'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_if.rdy = 1'b1;
        for (int i = 0; i < 8; i++) send(mk(i, 8, 64'h3000 + 64'(i)));
        wait_empty();

        w = 0;
        while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done) && w < 60000) begin
            @(posedge clk);
            w++;
        end
        chk("rnd_done", 80'({g_rnd[0].done, g_rnd[1].done, g_rnd[2].done}), 80'(3'b111));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- stressed instances ----------------
    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int NS = (g == 0) ? 0 : ((g == 1) ? 1 : 4);
        localparam int OW = (NS > 0) ? $clog2(2 * NS + 1) : 1;

        if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(8)) ri ();
        if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(8)) ro ();
        logic [OW-1:0] rocc;
        logic          rrst;
        beat_t         q[$];
        beat_t         c;
        bit            done = 1'b0;
        int            rcv = 0;

        pipeline_bp_if_multi #(.DAT_BYTS(8), .CTL_BITS(8), .NUM_STAGES(NS), .RANDOM_BP(30)) rdut (
            .i_clk(clk), .i_rst(rrst), .i_if(ri), .o_if(ro), .o_occ(rocc));

        initial begin
            beat_t       b;
            logic [95:0] r;
            int          w;
            rrst = 1'b1;
            ri.val = 1'b0;
            {ri.sop, ri.eop, ri.err, ri.mod, ri.ctl, ri.dat} = '0;
            repeat (3) @(posedge clk);
            #1;
            rrst = 1'b0;
            for (int i = 0; i < NB; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                r = {$urandom, $urandom, $urandom};
                b = r[77:0];
                ri.val = 1'b1;
                {ri.sop, ri.eop, ri.err, ri.mod, ri.ctl, ri.dat} = b;
                w = 0;
                @(negedge clk);
                while (!ri.rdy && w < 1000) begin
                    @(negedge clk);
                    w++;
                end
                if (!ri.rdy) begin
                    chk($sformatf("rnd%0d_send_rdy", NS), 80'(ri.rdy), 80'(1));
                    break;
                end
                q.push_back(b);
                @(posedge clk);
                #1;
                ri.val = 1'b0;
            end
            w = 0;
            while (rcv < NB && w < 20000) begin
                @(negedge clk);
                w++;
            end
            repeat (2) @(negedge clk);
            chk($sformatf("rnd%0d_count", NS), 80'(rcv), 80'(NB));
            chk($sformatf("rnd%0d_left", NS), 80'(q.size()), 80'(0));
            done = 1'b1;
        end

        initial begin
            ro.rdy = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                ro.rdy = 1'($urandom_range(0, 1));
            end
        end

        always @(negedge clk) begin
            #2;
            if (!rrst) begin
                chk($sformatf("rnd%0d_occ", NS), 80'(rocc),
                    80'(q.size() - ((ri.val && ri.rdy) ? 1 : 0)));
                if (ro.val && ro.rdy) begin
                    c = {ro.sop, ro.eop, ro.err, ro.mod, ro.ctl, ro.dat};
                    chk($sformatf("rnd%0d_noX", NS), 80'($isunknown(c)), 80'(0));
                    if (q.size() == 0) chk($sformatf("rnd%0d_underflow", NS), 80'(q.size()), 80'(1));
                    else chk($sformatf("rnd%0d_beat", NS), 80'(c), 80'(q.pop_front()));
                    rcv++;
                end
            end
        end
    end
endmodule
